watch_time_setter: RTL and testbench

Time-keeping and user-setting controller for the digital watch. It debounces the three push buttons, runs the hour/min/sec counters, and implements the NORMAL/SETTING mode and field-select logic. It drives the mode, set_pos, sw2 and dc_hour/dc_min/dc_sec inputs of the FND display block, which remains a pure consumer.

---
 rtl/watch_time_setter.sv | 187 ++++++++++++++++++
 tb/tb_watch_time_setter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_time_setter.sv
// Watch time-keeping and setting controller: debounces three buttons, runs the
// hh:mm:ss counters and handles NORMAL/SETTING mode, field select and auto-repeat.
module watch_time_setter #(
    parameter int TICK_DIV     = 50_000_000,
    parameter int DEBOUNCE_CYC = 500_000,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw0,
    input  logic       sw1,
    input  logic       sw2,
    output logic       mode,
    output logic [2:0] set_pos,
    output logic       sw2_held,
    output logic [4:0] dc_hour,
    output logic [5:0] dc_min,
    output logic [5:0] dc_sec,
    output logic       sec_tick
);

    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW = $clog2(RMAX + 1);

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [RW-1:0] RPT_DELAY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RPT_RATE  = RW'(REPEAT_RATE);

    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_SETTING = 1'b1
    } state_t;

    // Button vectors are ordered {sw2, sw1, sw0}.
    logic [2:0]    raw;
    logic [2:0]    sync1_q, sync2_q;
    logic [2:0]    db_q, db_d;
    logic [2:0]    press_q, press_d;
    logic [DW-1:0] deb_cnt_q [3];
    logic [DW-1:0] deb_cnt_d [3];

    state_t        state_q, state_d;
    logic [2:0]    pos_q, pos_d;
    logic [4:0]    hour_q, hour_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic          tick_q, tick_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [RW-1:0] rpt_q, rpt_d;
    logic          rpt_phase_q, rpt_phase_d;
    logic          rpt_fire;

    assign raw = {sw2, sw1, sw0};

    // A level change is accepted only after DEBOUNCE_CYC consecutive mismatching cycles.
    always_comb begin
        db_d    = db_q;
        press_d = '0;
        for (int i = 0; i < 3; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    db_d[i]    = sync2_q[i];
                    press_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    // Phase 0 waits REPEAT_DELAY from the debounced rise; phase 1 fires every REPEAT_RATE.
    assign rpt_fire = db_q[2] && (rpt_phase_q ? (rpt_q == RPT_RATE) : (rpt_q == RPT_DELAY));

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        pre_d       = pre_q;
        tick_d      = 1'b0;
        rpt_d       = rpt_q;
        rpt_phase_d = rpt_phase_q;

        if (!db_q[2]) begin
            rpt_d       = '0;
            rpt_phase_d = 1'b0;
        end else if (rpt_fire) begin
            rpt_d       = RW'(1);
            rpt_phase_d = 1'b1;
        end else begin
            rpt_d = rpt_q + RW'(1);
        end

        case (state_q)
            ST_NORMAL: begin
                if (pre_q == PRE_LAST) begin
                    pre_d  = '0;
                    tick_d = 1'b1;
                    if (sec_q == 6'd59) begin
                        sec_d = '0;
                        if (min_q == 6'd59) begin
                            min_d  = '0;
                            hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
                if (press_q[0]) begin
                    state_d     = ST_SETTING;
                    pos_d       = 3'b100;
                    rpt_d       = '0;
                    rpt_phase_d = 1'b0;
                end
            end
            ST_SETTING: begin
                pre_d = '0;
                if (press_q[0]) begin
                    state_d = ST_NORMAL;
                end else if (press_q[1]) begin
                    pos_d = {pos_q[0], pos_q[2:1]};
                end else if (press_q[2] || rpt_fire) begin
                    case (pos_q)
                        3'b100:  hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                        3'b010:  min_d  = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                        3'b001:  sec_d  = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
                        default: ;
                    endcase
                end
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_q        <= '0;
            press_q     <= '0;
            for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
            state_q     <= ST_NORMAL;
            pos_q       <= 3'b100;
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            tick_q      <= 1'b0;
            pre_q       <= '0;
            rpt_q       <= '0;
            rpt_phase_q <= 1'b0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            db_q        <= db_d;
            press_q     <= press_d;
            for (int i = 0; i < 3; i++) deb_cnt_q[i] <= deb_cnt_d[i];
            state_q     <= state_d;
            pos_q       <= pos_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            tick_q      <= tick_d;
            pre_q       <= pre_d;
            rpt_q       <= rpt_d;
            rpt_phase_q <= rpt_phase_d;
        end
    end

    assign mode     = (state_q == ST_SETTING);
    assign set_pos  = pos_q;
    assign sw2_held = db_q[2];
    assign dc_hour  = hour_q;
    assign dc_min   = min_q;
    assign dc_sec   = sec_q;
    assign sec_tick = tick_q;

endmodule

// File: tb/tb_watch_time_setter.sv
// Directed bench for watch_time_setter with shortened timing constants.
module tb_watch_time_setter;

    localparam int TICK_DIV     = 10;
    localparam int DEBOUNCE_CYC = 4;
    localparam int REPEAT_DELAY = 20;
    localparam int REPEAT_RATE  = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       sw0, sw1, sw2;
    logic       mode;
    logic [2:0] set_pos;
    logic       sw2_held;
    logic [4:0] dc_hour;
    logic [5:0] dc_min;
    logic [5:0] dc_sec;
    logic       sec_tick;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0] mask;   // {sw2, sw1, sw0}
        int         reps;
        logic       mode;
        logic [2:0] pos;
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
    } vec_t;

    vec_t vecs[16];

    watch_time_setter #(
        .TICK_DIV    (TICK_DIV),
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sw0     (sw0),
        .sw1     (sw1),
        .sw2     (sw2),
        .mode    (mode),
        .set_pos (set_pos),
        .sw2_held(sw2_held),
        .dc_hour (dc_hour),
        .dc_min  (dc_min),
        .dc_sec  (dc_sec),
        .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_state(input string tag, input logic m, input logic [2:0] p,
                               input logic [4:0] h, input logic [5:0] mi, input logic [5:0] s);
        check({tag, ".mode"}, 32'(mode), 32'(m));
        check({tag, ".set_pos"}, 32'(set_pos), 32'(p));
        check({tag, ".hour"}, 32'(dc_hour), 32'(h));
        check({tag, ".min"}, 32'(dc_min), 32'(mi));
        check({tag, ".sec"}, 32'(dc_sec), 32'(s));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_state(tag, 1'b0, 3'b100, 5'd0, 6'd0, 6'd0);
        check({tag, ".sw2_held"}, 32'(sw2_held), 32'd0);
        check({tag, ".sec_tick"}, 32'(sec_tick), 32'd0);
    endtask

    // Reset, then optionally hold sw0 across release so SETTING is entered before any tick.
    task automatic reset_into(input logic enter_setting);
        reset = 1'b0;
        sw0 = enter_setting;
        sw1 = 1'b0;
        sw2 = 1'b0;
        step(3);
        reset = 1'b1;
        step(10);
        sw0 = 1'b0;
        step(10);
    endtask

    task automatic press_mask(input logic [2:0] m, input int reps);
        for (int r = 0; r < reps; r++) begin
            {sw2, sw1, sw0} = m;
            step(10);
            {sw2, sw1, sw0} = 3'b000;
            step(10);
        end
    endtask

    initial begin
        int ticks, last, gap_bad, found, first;
        logic ever_high;

        vecs[0]  = '{3'b010, 1,  1'b1, 3'b010, 5'd0,  6'd0,  6'd0};
        vecs[1]  = '{3'b010, 1,  1'b1, 3'b001, 5'd0,  6'd0,  6'd0};
        vecs[2]  = '{3'b010, 1,  1'b1, 3'b100, 5'd0,  6'd0,  6'd0};
        vecs[3]  = '{3'b100, 1,  1'b1, 3'b100, 5'd1,  6'd0,  6'd0};
        vecs[4]  = '{3'b100, 22, 1'b1, 3'b100, 5'd23, 6'd0,  6'd0};
        vecs[5]  = '{3'b100, 1,  1'b1, 3'b100, 5'd0,  6'd0,  6'd0};
        vecs[6]  = '{3'b010, 1,  1'b1, 3'b010, 5'd0,  6'd0,  6'd0};
        vecs[7]  = '{3'b100, 59, 1'b1, 3'b010, 5'd0,  6'd59, 6'd0};
        vecs[8]  = '{3'b010, 1,  1'b1, 3'b001, 5'd0,  6'd59, 6'd0};
        vecs[9]  = '{3'b100, 59, 1'b1, 3'b001, 5'd0,  6'd59, 6'd59};
        vecs[10] = '{3'b100, 1,  1'b1, 3'b001, 5'd0,  6'd59, 6'd0};
        vecs[11] = '{3'b110, 1,  1'b1, 3'b100, 5'd0,  6'd59, 6'd0};
        vecs[12] = '{3'b010, 2,  1'b1, 3'b001, 5'd0,  6'd59, 6'd0};
        vecs[13] = '{3'b100, 59, 1'b1, 3'b001, 5'd0,  6'd59, 6'd59};
        vecs[14] = '{3'b010, 1,  1'b1, 3'b100, 5'd0,  6'd59, 6'd59};
        vecs[15] = '{3'b100, 23, 1'b1, 3'b100, 5'd23, 6'd59, 6'd59};

        // Reset values, then free-running time for 600 seconds.
        reset = 1'b0;
        {sw2, sw1, sw0} = 3'b000;
        step(2);
        check_reset_outputs("reset");
        reset = 1'b1;
        ticks = 0;
        last = 0;
        gap_bad = 0;
        for (int c = 1; c <= 6000; c++) begin
            step(1);
            if (sec_tick) begin
                ticks++;
                if (c - last != TICK_DIV) gap_bad++;
                last = c;
            end
        end
        check("run.tick_count", 32'(ticks), 32'd600);
        check("run.tick_spacing_errors", 32'(gap_bad), 32'd0);
        check_state("run600", 1'b0, 3'b100, 5'd0, 6'd10, 6'd0);

        // Short glitches must never reach the debounced level.
        ever_high = 1'b0;
        for (int p = 0; p < 5; p++) begin
            sw2 = 1'b1;
            for (int k = 0; k < 3; k++) begin step(1); ever_high |= sw2_held; end
            sw2 = 1'b0;
            for (int k = 0; k < 3; k++) begin step(1); ever_high |= sw2_held; end
        end
        step(6);
        ever_high |= sw2_held;
        check("debounce.glitch_held", 32'(ever_high), 32'd0);
        sw2 = 1'b1;
        step(5);
        check("debounce.held_at_t0p5", 32'(sw2_held), 32'd0);
        step(1);
        check("debounce.held_at_t0p6", 32'(sw2_held), 32'd1);
        sw2 = 1'b0;
        step(10);

        // Table-driven edits in SETTING mode.
        reset_into(1'b1);
        check_state("enter", 1'b1, 3'b100, 5'd0, 6'd0, 6'd0);
        for (int i = 0; i < 16; i++) begin
            press_mask(vecs[i].mask, vecs[i].reps);
            check_state($sformatf("vec%0d", i), vecs[i].mode, vecs[i].pos,
                        vecs[i].hour, vecs[i].min, vecs[i].sec);
        end

        // sw0 and sw2 debounced together: leave SETTING, fields untouched, first tick 10 cycles on.
        sw0 = 1'b1;
        sw2 = 1'b1;
        step(6);
        check("exit.mode_before", 32'(mode), 32'd1);
        step(1);
        check_state("exit", 1'b0, 3'b100, 5'd23, 6'd59, 6'd59);
        sw0 = 1'b0;
        sw2 = 1'b0;
        found = 0;
        first = 0;
        for (int c = 1; c <= 30 && found == 0; c++) begin
            step(1);
            if (sec_tick) begin
                found = 1;
                first = c;
            end
        end
        check("exit.first_tick_delay", 32'(first), 32'(TICK_DIV));
        check_state("wrap", 1'b0, 3'b100, 5'd0, 6'd0, 6'd0);

        // Auto-repeat on minutes: 41 held cycles give increments at 0,20,25,30,35,40.
        reset_into(1'b1);
        press_mask(3'b010, 1);
        check_state("rpt.setup", 1'b1, 3'b010, 5'd0, 6'd0, 6'd0);
        sw2 = 1'b1;
        step(41);
        sw2 = 1'b0;
        step(10);
        check_state("rpt.done", 1'b1, 3'b010, 5'd0, 6'd6, 6'd0);
        step(40);
        check("rpt.after_release.min", 32'(dc_min), 32'd6);
        press_mask(3'b001, 1);
        check("reenter.mode_off", 32'(mode), 32'd0);
        press_mask(3'b001, 1);
        check("reenter.mode_on", 32'(mode), 32'd1);
        check("reenter.set_pos", 32'(set_pos), 32'(3'b100));

        // Reset in the middle of a held-button repeat.
        reset_into(1'b1);
        press_mask(3'b100, 12);
        press_mask(3'b010, 1);
        press_mask(3'b100, 34);
        press_mask(3'b010, 1);
        press_mask(3'b100, 56);
        check_state("preset", 1'b1, 3'b001, 5'd12, 6'd34, 6'd56);
        sw2 = 1'b1;
        step(30);
        check("preset.repeat_sec", 32'(dc_sec), 32'd58);
        reset = 1'b0;
        #2;
        check_reset_outputs("midreset");
        sw0 = 1'b1;
        step(2);
        reset = 1'b1;
        step(5);
        check("rerel.held_t5", 32'(sw2_held), 32'd0);
        step(1);
        check("rerel.held_t6", 32'(sw2_held), 32'd1);
        check("rerel.mode_t6", 32'(mode), 32'd0);
        step(1);
        check_state("rerel.enter", 1'b1, 3'b100, 5'd0, 6'd0, 6'd0);
        sw0 = 1'b0;
        step(20);
        check_state("rerel.no_inc", 1'b1, 3'b100, 5'd0, 6'd0, 6'd0);
        step(1);
        check("rerel.first_repeat.hour", 32'(dc_hour), 32'd1);
        sw2 = 1'b0;
        step(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
